// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle control sequencer
package ctrl_pkg;

    localparam logic [2:0] S_RSTV   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_LUI = 4'd3;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LB    = 6'b100000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] FN_ADD    = 6'b100000;

    localparam logic [1:0] WB_MDR = 2'b00;
    localparam logic [1:0] WB_EXT = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b10;

    localparam logic [1:0] DEST_RT = 2'b00;
    localparam logic [1:0] DEST_RD = 2'b01;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD_B,
        CLS_LOAD_W,
        CLS_STORE
    } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - unified memory request/ready port
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - opcode/funct to instruction class and EXEC controls
module mc_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic [3:0]   alu_op,
    output logic         use_imm,
    output logic         imm_sign,
    output logic         dest_rd
);
    always_comb begin
        cls      = CLS_NOP;
        alu_op   = OP_NOP;
        use_imm  = 1'b1;
        imm_sign = 1'b0;
        dest_rd  = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                use_imm = 1'b0;
                dest_rd = 1'b1;
                if (funct == FN_ADD) begin
                    cls    = CLS_ALU;
                    alu_op = OP_ADD;
                end
            end
            OPC_ORI: begin cls = CLS_ALU;    alu_op = OP_OR;  end
            OPC_LUI: begin cls = CLS_ALU;    alu_op = OP_LUI; end
            OPC_LB:  begin cls = CLS_LOAD_B; alu_op = OP_ADD; imm_sign = 1'b1; end
            OPC_LW:  begin cls = CLS_LOAD_W; alu_op = OP_ADD; imm_sign = 1'b1; end
            OPC_SW:  begin cls = CLS_STORE;  alu_op = OP_ADD; imm_sign = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Optional memory watchdog: MULTICYCLE_CTRL_TIMEOUT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    multicycle_ctrl_if.master mem,
    output logic              ir_write_en,
    output logic              mdr_write_en,
    output logic              pc_write_en,
    output logic              pc_reset_load,
    output logic              reg_write_en,
    output logic [1:0]        reg_dest_sel,
    output logic              alu_src_a_sel,
    output logic              alu_src_b_sel,
    output logic [3:0]        alu_op,
    output logic              imm_ext_sign,
    output logic              data_ext_byte,
    output logic              data_ext_sign,
    output logic [1:0]        wb_sel,
    output logic              instr_done,
    output logic              timeout
);
    logic [2:0]   state, next;
    instr_class_t cls;
    logic [3:0]   dec_alu_op;
    logic         dec_use_imm, dec_imm_sign, dec_dest_rd;
    logic         req_c, we_c, ir_c, mdr_c, pcw_c, rwe_c, done_c;
    logic         expired;

    mc_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (cls),
        .alu_op   (dec_alu_op),
        .use_imm  (dec_use_imm),
        .imm_sign (dec_imm_sign),
        .dest_rd  (dec_dest_rd)
    );

    always_comb begin
        next          = state;
        req_c         = 1'b0;
        we_c          = 1'b0;
        ir_c          = 1'b0;
        mdr_c         = 1'b0;
        pcw_c         = 1'b0;
        rwe_c         = 1'b0;
        done_c        = 1'b0;
        mem.mem_addr_sel = 1'b0;
        pc_reset_load = 1'b0;
        reg_dest_sel  = DEST_RT;
        alu_src_b_sel = 1'b0;
        alu_op        = OP_NOP;
        imm_ext_sign  = 1'b0;
        data_ext_byte = 1'b0;
        data_ext_sign = 1'b0;
        wb_sel        = WB_MDR;
        case (state)
            S_RSTV: begin
                pc_reset_load = 1'b1;
                next          = S_FETCH;
            end
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_c  = 1'b1;
                    pcw_c = 1'b1;
                    next  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls == CLS_NOP) begin
                    done_c = 1'b1;
                    next   = S_FETCH;
                end else begin
                    next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op        = dec_alu_op;
                alu_src_b_sel = dec_use_imm;
                imm_ext_sign  = dec_imm_sign;
                next          = (cls == CLS_ALU) ? S_WB : S_MEM;
            end
            S_MEM: begin
                req_c            = 1'b1;
                mem.mem_addr_sel = 1'b1;
                we_c             = (cls == CLS_STORE);
                if (mem.mem_ready) begin
                    if (cls == CLS_STORE) begin
                        done_c = 1'b1;
                        next   = S_FETCH;
                    end else begin
                        mdr_c = 1'b1;
                        next  = S_WB;
                    end
                end
            end
            S_WB: begin
                rwe_c        = 1'b1;
                done_c       = 1'b1;
                reg_dest_sel = dec_dest_rd ? DEST_RD : DEST_RT;
                case (cls)
                    CLS_ALU:    wb_sel = WB_ALU;
                    CLS_LOAD_B: begin
                        wb_sel        = WB_EXT;
                        data_ext_byte = 1'b1;
                        data_ext_sign = 1'b1;
                    end
                    default:    wb_sel = WB_MDR;
                endcase
                next = S_FETCH;
            end
            default: next = S_RSTV;
        endcase
        if (expired) next = S_RSTV;
    end

    // Reset must suppress every strobe at once, even while the state is still mid-transaction.
    assign mem.mem_req   = req_c  & ~reset;
    assign mem.mem_we    = we_c   & ~reset;
    assign ir_write_en   = ir_c   & ~reset;
    assign mdr_write_en  = mdr_c  & ~reset;
    assign pc_write_en   = pcw_c  & ~reset;
    assign reg_write_en  = rwe_c  & ~reset;
    assign instr_done    = done_c & ~reset;
    assign alu_src_a_sel = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) state <= S_RSTV;
        else       state <= next;
    end

    if (WAIT_MAX < 1 || WAIT_MAX > 15) begin : g_wait_max_out_of_range
    end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       timeout_q;
    logic       waiting;

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem.mem_ready;
    assign expired = waiting && (wait_cnt == 4'(WAIT_MAX - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 4'd1 : 4'd0;
            if (expired) timeout_q <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write_en;
        logic       mdr_write_en;
        logic       pc_write_en;
        logic       pc_reset_load;
        logic       reg_write_en;
        logic [1:0] reg_dest_sel;
        logic       alu_src_a_sel;
        logic       alu_src_b_sel;
        logic [3:0] alu_op;
        logic       imm_ext_sign;
        logic       data_ext_byte;
        logic       data_ext_sign;
        logic [1:0] wb_sel;
        logic       instr_done;
        logic       timeout;
    } out_t;

    typedef enum {K_ADD, K_ORI, K_LUI, K_LB, K_LW, K_SW, K_NOP} kind_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       ir_write_en, mdr_write_en, pc_write_en, pc_reset_load, reg_write_en;
    logic [1:0] reg_dest_sel, wb_sel;
    logic       alu_src_a_sel, alu_src_b_sel, imm_ext_sign, data_ext_byte, data_ext_sign;
    logic [3:0] alu_op;
    logic       instr_done, timeout;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem           (bus),
        .ir_write_en   (ir_write_en),
        .mdr_write_en  (mdr_write_en),
        .pc_write_en   (pc_write_en),
        .pc_reset_load (pc_reset_load),
        .reg_write_en  (reg_write_en),
        .reg_dest_sel  (reg_dest_sel),
        .alu_src_a_sel (alu_src_a_sel),
        .alu_src_b_sel (alu_src_b_sel),
        .alu_op        (alu_op),
        .imm_ext_sign  (imm_ext_sign),
        .data_ext_byte (data_ext_byte),
        .data_ext_sign (data_ext_sign),
        .wb_sel        (wb_sel),
        .instr_done    (instr_done),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail = 0;
    out_t exp_o;
    bit   exp_valid = 1'b0;
    bit   junk = 1'b0;
    int   cyc_no = 0, last_ir = 0, ir_delta = 0;
    int   n_prl = 0, n_done = 0, n_mdr = 0, n_rwe = 0, n_mreq = 0, n_write = 0;

    always @(negedge clk) begin : compare
        out_t act;
        act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_write_en, mdr_write_en,
               pc_write_en, pc_reset_load, reg_write_en, reg_dest_sel, alu_src_a_sel,
               alu_src_b_sel, alu_op, imm_ext_sign, data_ext_byte, data_ext_sign,
               wb_sel, instr_done, timeout};
        cyc_no++;
        if (exp_valid) begin
            n_assert++;
            if (act !== exp_o) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got %h expected %h", cyc_no, act, exp_o);
            end
        end
        if (ir_write_en) begin
            ir_delta = cyc_no - last_ir;
            last_ir  = cyc_no;
        end
        n_prl   += int'(pc_reset_load);
        n_done  += int'(instr_done);
        n_mdr   += int'(mdr_write_en);
        n_rwe   += int'(reg_write_en);
        n_mreq  += int'(bus.mem_req & bus.mem_addr_sel);
        n_write += int'(bus.mem_req & bus.mem_we & bus.mem_ready);
    end

    function automatic out_t base();
        out_t e;
        e        = '0;
        e.alu_op = OP_NOP;
        return e;
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b100000) ? K_ADD : K_NOP;
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100000: return K_LB;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            default:   return K_NOP;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_assert++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic clr();
        n_prl = 0; n_done = 0; n_mdr = 0; n_rwe = 0; n_mreq = 0; n_write = 0;
    endtask

    task automatic cyc(input bit rst, input bit rdy, input out_t e);
        reset         = rst;
        bus.mem_ready = rdy;
        exp_o         = e;
        exp_valid     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One instruction from its first FETCH cycle; abort_at >= 0 raises reset on that MEM wait cycle.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input int abort_at, input int prev_lat);
        out_t  e;
        kind_t k;
        k = classify(op, fn);
        e = base();
        e.mem_req = 1'b1;
        repeat (fw) cyc(1'b0, 1'b0, e);
        e.ir_write_en = 1'b1;
        e.pc_write_en = 1'b1;
        cyc(1'b0, 1'b1, e);
        if (prev_lat >= 0) check("latency", ir_delta, prev_lat);
        opcode = op;
        funct  = fn;
        junk   = ~junk;
        e = base();
        e.instr_done = (k == K_NOP);
        cyc(1'b0, junk, e);
        if (k == K_NOP) return;
        e = base();
        e.alu_src_b_sel = (k != K_ADD);
        e.imm_ext_sign  = (k == K_LB || k == K_LW || k == K_SW);
        e.alu_op        = (k == K_ORI) ? OP_OR : (k == K_LUI) ? OP_LUI : OP_ADD;
        cyc(1'b0, ~junk, e);
        if (k == K_LB || k == K_LW || k == K_SW) begin
            e = base();
            e.mem_req      = 1'b1;
            e.mem_addr_sel = 1'b1;
            e.mem_we       = (k == K_SW);
            for (int i = 0; i < mw; i++) begin
                if (i == abort_at) begin
                    e.mem_req = 1'b0;
                    e.mem_we  = 1'b0;
                    cyc(1'b1, 1'b0, e);
                    e = base();
                    e.pc_reset_load = 1'b1;
                    cyc(1'b0, junk, e);
                    return;
                end
                cyc(1'b0, 1'b0, e);
            end
            e.instr_done   = (k == K_SW);
            e.mdr_write_en = (k != K_SW);
            cyc(1'b0, 1'b1, e);
            if (k == K_SW) return;
        end
        e = base();
        e.reg_write_en  = 1'b1;
        e.instr_done    = 1'b1;
        e.reg_dest_sel  = (k == K_ADD) ? 2'b01 : 2'b00;
        e.wb_sel        = (k == K_LW) ? 2'b00 : (k == K_LB) ? 2'b01 : 2'b10;
        e.data_ext_byte = (k == K_LB);
        e.data_ext_sign = (k == K_LB);
        cyc(1'b0, junk, e);
    endtask

    initial begin
        out_t e;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        e = base();
        e.pc_reset_load = 1'b1;
        clr();
        cyc(1'b1, 1'b1, e);
        cyc(1'b1, 1'b0, e);
        check("reset_cycles_prl", n_prl, 2);
        clr();
        cyc(1'b0, 1'b1, e);

        run(6'b000000, 6'b100000, 0, 0, -1, -1);
        check("add_prl_after_release", n_prl, 1);
        check("add_done", n_done, 1);
        check("add_rwe", n_rwe, 1);

        clr();
        run(6'b000010, 6'b000000, 0, 0, -1, 4);
        check("nop_done", n_done, 1);
        check("nop_rwe", n_rwe, 0);

        run(6'b001101, 6'b010101, 2, 0, -1, 4);
        run(6'b001111, 6'b000001, 0, 0, -1, 4);
        run(6'b100011, 6'b000011, 0, 1, -1, 4);

        clr();
        run(6'b100000, 6'b111111, 1, 3, -1, 7);
        check("lb_mem_req_cycles", n_mreq, 4);
        check("lb_mdr", n_mdr, 1);
        check("lb_done", n_done, 1);

        run(6'b101011, 6'b000000, 0, 0, -1, 8);

        clr();
        run(6'b101011, 6'b000000, 0, 3, 1, 4);
        check("sw_abort_writes", n_write, 0);
        check("sw_abort_prl", n_prl, 1);
        check("sw_abort_done", n_done, 0);

        run(6'b000000, 6'b100010, 0, 0, -1, 6);
        run(6'b000000, 6'b100000, 0, 0, -1, 2);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        e = base();
        e.mem_req = 1'b1;
        repeat (15) cyc(1'b0, 1'b0, e);
        e = base();
        e.pc_reset_load = 1'b1;
        e.timeout = 1'b1;
        cyc(1'b0, 1'b0, e);
        e = base();
        e.mem_req = 1'b1;
        e.timeout = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, e);
        e = base();
        e.timeout = 1'b1;
        cyc(1'b1, 1'b0, e);
        e = base();
        e.pc_reset_load = 1'b1;
        cyc(1'b0, 1'b0, e);
`endif

        exp_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the 32-bit RISC datapath, replacing the single-cycle decode.
- Instruction and data share one memory port with a ready handshake.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath mux selects, register enables, ALU op and memory request lines per state.
- Sits between the IR opcode/funct fields, the unified memory and the datapath.

Parameters:
- WAIT_MAX, 15, maximum memory wait cycles before the request is flagged as timed out (used only by the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  store-word write strobe (qualified by mem_req)
- mem_addr_sel  out  1  0 = PC, 1 = ALU-out register
- ir_write_en  out  1  load IR from memory data
- mdr_write_en  out  1  load MDR from memory data
- pc_write_en  out  1  PC <= PC+4
- pc_reset_load  out  1  PC <= reset vector
- reg_write_en  out  1  register file write
- reg_dest_sel  out  2  00 = rt, 01 = rd
- alu_src_a_sel  out  1  0 = rs, 1 = shamt
- alu_src_b_sel  out  1  0 = rt, 1 = extended immediate
- alu_op  out  4  ALU operation (package constants)
- imm_ext_sign  out  1  1 = sign-extend immediate, 0 = zero-extend
- data_ext_byte  out  1  1 = byte load path
- data_ext_sign  out  1  1 = signed byte extension
- wb_sel  out  2  00 = MDR word, 01 = extended MDR, 10 = ALU-out
- instr_done  out  1  one-cycle pulse when an instruction retires
- timeout  out  1  sticky memory-timeout flag (0 without the optional feature)

Behaviour:
- States: RSTV, FETCH, DECODE, EXEC, MEM, WB. The 3-bit state register is the only core sequential element.
- Reset
  - Sampled at the edge: next state is RSTV from any state, including mid-wait in FETCH or MEM.
  - While reset is high, mem_req, mem_we, reg_write_en, pc_write_en and ir_write_en are gated to 0 combinationally. An aborted store never writes.
- Output defaults in every state: all enables and strobes 0, selects 0, alu_op = OP_NOP. "Don't care" is never driven as X.
- RSTV
  - pc_reset_load = 1 for one cycle, then FETCH.
  - Reset output values: every output 0 except pc_reset_load = 1, and alu_op = OP_NOP.
- FETCH
  - mem_req = 1, mem_addr_sel = 0.
  - Stays in FETCH while mem_ready = 0.
  - On mem_ready = 1: ir_write_en = 1 and pc_write_en = 1 in the same cycle, then DECODE.
- DECODE
  - Supported set: ADD (op 000000, funct 100000), ORI (001101), LUI (001111), LB (100000), LW (100011), SW (101011).
  - Supported instruction goes to EXEC.
  - Anything else retires as a NOP: instr_done = 1, then FETCH.
- EXEC (result captured in the ALU-out register every cycle)
  - ADD: srcA = 0, srcB = 0, OP_ADD.
  - ORI: srcB = 1, imm_ext_sign = 0, OP_OR.
  - LUI: srcB = 1, OP_LUI.
  - LB/LW/SW: srcB = 1, imm_ext_sign = 1, OP_ADD.
  - ALU ops go to WB; loads and stores go to MEM.
- MEM
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for SW only.
  - Holds while mem_ready = 0, with all outputs stable.
  - On ready, SW: instr_done = 1, then FETCH.
  - On ready, loads: mdr_write_en = 1, then WB.
- WB
  - reg_write_en = 1 and instr_done = 1.
  - reg_dest_sel = 01 for ADD, 00 otherwise.
  - wb_sel = 10 for ALU ops, 00 for LW, 01 for LB (data_ext_byte = 1, data_ext_sign = 1).
  - Next state FETCH.
- Latency with zero-wait memory, measured FETCH to next FETCH:
  - ALU op: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - NOP: 2 cycles
  - Each memory wait cycle adds 1.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready = 0.
  - When the count reaches WAIT_MAX: timeout is set (sticky until reset), the request is dropped, and the state goes to RSTV.
- Undefined: no counter, timeout tied to 0, and the controller waits indefinitely.

Decomposition:
- Shared package ctrl_pkg:
  - State encoding.
  - ALU op constants OP_ADD, OP_OR, OP_LUI, OP_NOP.
  - Opcode/funct constants.
  - wb_sel and reg_dest_sel encodings.
- One sub-module, mc_decode: combinational opcode/funct to instruction-class decode (ALU, LOAD_B, LOAD_W, STORE, NOP), instantiated once.

Test Plan:
- Reset held 2 cycles, then released
  - -> exactly one cycle of pc_reset_load = 1, then FETCH with mem_req = 1 and mem_addr_sel = 0.
  - All enables are 0 during reset.
- ADD (000000/100000), mem_ready always 1
  - -> WB on cycle 4 with reg_write_en = 1, reg_dest_sel = 01, wb_sel = 10.
  - -> instr_done pulses once.
- LB (100000) with 3 wait cycles in MEM
  - -> mem_req is held 4 cycles, mdr_write_en = 1 only on the ready cycle.
  - -> WB has wb_sel = 01, data_ext_byte = 1, data_ext_sign = 1.
- SW (101011) with reset asserted during the 2nd MEM wait cycle
  - -> mem_we is 0 in the reset cycle and no write strobe is seen.
  - -> next state is RSTV.
- Unsupported opcode 000010
  - -> DECODE pulses instr_done, returns to FETCH after 2 cycles, and reg_write_en never rises.
- MULTICYCLE_CTRL_TIMEOUT_EN defined, WAIT_MAX = 15, mem_ready stuck at 0 in FETCH
  - -> timeout = 1 after 15 wait cycles, then RSTV.
  - -> timeout stays 1 until reset.
